cfg_chain_loader: RTL and testbench

Serial configuration loader for the switch-cell configuration chain. It accepts configuration words from a host over a valid/ready stream and serialises them LSB-first onto the daisy-chained config cells. It gates shifting with a clock-enable, and counts exactly CHAIN_LEN bits per load. It sits between the host/bitstream source and the first config cell of a fabric region (for example a chain of FULLYCONN-style mux cells).

---
 rtl/cfg_chain_loader.sv | 203 ++++++++++++++++++++
 tb/tb_cfg_chain_loader.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/cfg_chain_loader.sv
// -----------------------------------------------------------------------------
// cfg_chain_loader
//
// Serial configuration loader for a daisy-chained switch-cell config chain.
// Host words arrive on a valid/ready stream and are shifted LSB-first into
// the chain. Exactly CHAIN_LEN bits are shifted per load. Unused upper bits
// of the final word are dropped.
//
// Optional feature macro: CFG_LOADER_VERIFY_EN
//   When defined, a VERIFY pass follows the load. The chain is rotated
//   CHAIN_LEN times through a loopback (chain_sdi -> chain_sdo), which leaves
//   its contents unchanged. The parity of the bits read back is compared with
//   the parity of the bits loaded, and a mismatch sets the sticky 'error'.
//   When undefined, SHIFT goes straight to DONE, error is tied low and
//   chain_sdi is ignored.
//
// Ports
//   config_clk      sole clock
//   config_reset    asynchronous, active-low reset
//   start           begin a load (sampled only when idle)
//   s_valid/s_ready host word handshake; s_data is the host word, bit 0 first
//   chain_shift_en  clock-enable to the chain clock gate (one bit per cycle)
//   chain_sdo       serial bit into the first cell (0 while not shifting)
//   chain_sdi       serial bit from the last cell (used by VERIFY only)
//   busy            high whenever the loader is not idle
//   done            one-cycle pulse when a load completes
//   error           verify parity mismatch; sticky until the next start
// -----------------------------------------------------------------------------
module cfg_chain_loader #(
    parameter int WORD_W    = 32,
    parameter int CHAIN_LEN = 64,
    parameter int CNT_W     = 16
) (
    input  logic              config_clk,
    input  logic              config_reset,
    input  logic              start,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [WORD_W-1:0] s_data,
    output logic              chain_shift_en,
    output logic              chain_sdo,
    input  logic              chain_sdi,
    output logic              busy,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        SHIFT  = 3'd2,
        VERIFY = 3'd3,
        DONE   = 3'd4
    } state_e;

    localparam logic [CNT_W-1:0] LEN_C  = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0] WORD_C = CNT_W'(WORD_W);
    localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

    state_e              state_q;
    logic [CNT_W-1:0]    cnt_q;      // bits shifted this load, or verify cycles
    logic [CNT_W-1:0]    rem_q;      // bits still to shift from the current word
    logic [WORD_W-1:0]   shreg_q;    // bits of the current word not yet on chain_sdo
    logic                s_ready_q;
    logic                shift_en_q;
    logic                sdo_q;
    logic                busy_q;
    logic                done_q;

    logic [CNT_W-1:0]    left_d;     // chain bits not yet loaded
    logic [CNT_W-1:0]    k_d;        // bits to take from the word being accepted

    assign left_d = LEN_C - cnt_q;
    // WORD_C is only selected when WORD_W < left_d, so its truncation is harmless.
    assign k_d    = (32'(left_d) > 32'(WORD_W)) ? WORD_C : left_d;

`ifdef CFG_LOADER_VERIFY_EN
    logic lpar_q;   // parity of bits driven onto the chain during SHIFT
    logic vpar_q;   // parity of bits read back during VERIFY
    logic err_q;
`endif

    // NOTE: every register below is written with non-blocking assignments so
    // that all state updates on an edge see the pre-edge values of each other.
    always_ff @(posedge config_clk or negedge config_reset) begin
        if (!config_reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rem_q      <= '0;
            shreg_q    <= '0;
            s_ready_q  <= 1'b0;
            shift_en_q <= 1'b0;
            sdo_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef CFG_LOADER_VERIFY_EN
            lpar_q     <= 1'b0;
            vpar_q     <= 1'b0;
            err_q      <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q   <= LOAD;
                        cnt_q     <= '0;
                        s_ready_q <= 1'b1;
                        busy_q    <= 1'b1;
`ifdef CFG_LOADER_VERIFY_EN
                        lpar_q    <= 1'b0;
                        vpar_q    <= 1'b0;
                        err_q     <= 1'b0;
`endif
                    end
                end

                LOAD: begin
                    // s_ready_q is high for the whole of LOAD, so s_valid alone
                    // completes the handshake.
                    if (s_valid) begin
                        state_q    <= SHIFT;
                        shreg_q    <= s_data >> 1;
                        sdo_q      <= s_data[0];
                        rem_q      <= k_d;
                        s_ready_q  <= 1'b0;
                        shift_en_q <= 1'b1;
                    end
                end

                SHIFT: begin
                    cnt_q <= cnt_q + ONE_C;
                    rem_q <= rem_q - ONE_C;
`ifdef CFG_LOADER_VERIFY_EN
                    lpar_q <= lpar_q ^ sdo_q;
`endif
                    if (rem_q == ONE_C) begin
                        sdo_q <= 1'b0;
                        if (cnt_q + ONE_C == LEN_C) begin
`ifdef CFG_LOADER_VERIFY_EN
                            state_q <= VERIFY;
                            cnt_q   <= '0;
`else
                            state_q    <= DONE;
                            shift_en_q <= 1'b0;
                            done_q     <= 1'b1;
`endif
                        end else begin
                            state_q    <= LOAD;
                            shift_en_q <= 1'b0;
                            s_ready_q  <= 1'b1;
                        end
                    end else begin
                        sdo_q   <= shreg_q[0];
                        shreg_q <= shreg_q >> 1;
                    end
                end

`ifdef CFG_LOADER_VERIFY_EN
                VERIFY: begin
                    cnt_q  <= cnt_q + ONE_C;
                    vpar_q <= vpar_q ^ chain_sdi;
                    if (cnt_q == LEN_C - ONE_C) begin
                        // Fold in the final read-back bit before comparing.
                        err_q      <= (vpar_q ^ chain_sdi) != lpar_q;
                        state_q    <= DONE;
                        shift_en_q <= 1'b0;
                        done_q     <= 1'b1;
                    end
                end
`endif

                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign s_ready        = s_ready_q;
    assign chain_shift_en = shift_en_q;
    assign busy           = busy_q;
    assign done           = done_q;

`ifdef CFG_LOADER_VERIFY_EN
    // The loopback is a straight wire during VERIFY: a register in the loop
    // would add a stage, and CHAIN_LEN rotations would no longer restore the
    // chain. The select itself is a registered state bit.
    assign chain_sdo = (state_q == VERIFY) ? chain_sdi : sdo_q;
    assign error     = err_q;
`else
    logic unused_chain_sdi;
    assign unused_chain_sdi = chain_sdi;
    assign chain_sdo        = sdo_q;
    assign error            = 1'b0;
`endif

endmodule

// File: tb/tb_cfg_chain_loader.sv
// -----------------------------------------------------------------------------
// tb_cfg_chain_loader
//
// Bench for cfg_chain_loader with WORD_W=32, CHAIN_LEN=40. The reference
// model builds, from the loading rules, the bit stream a load must produce
// and a cycle-by-cycle table of expected outputs. A 40-bit shift register
// models the chain, and its last bit feeds chain_sdi. Define
// CFG_LOADER_VERIFY_EN for both files to cover the verify pass.
// -----------------------------------------------------------------------------
module tb_cfg_chain_loader;

    localparam int WORD_W    = 32;
    localparam int CHAIN_LEN = 40;
    localparam int CNT_W     = 16;

    typedef struct packed {
        logic en;
        logic sdo;
        logic rdy;
        logic busy;
        logic done;
        logic err;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 start;
    logic                 s_valid;
    logic                 s_ready;
    logic [WORD_W-1:0]    s_data;
    logic                 chain_shift_en;
    logic                 chain_sdo;
    logic                 chain_sdi;
    logic                 busy;
    logic                 done;
    logic                 error;

    logic [CHAIN_LEN-1:0] chain_m   = '0;
    logic [CHAIN_LEN-1:0] flip_mask = '0;

    int vectors     = 0;
    int miscompares = 0;
    bit prev_err    = 1'b0;

    always #5 clk = ~clk;

    cfg_chain_loader #(
        .WORD_W    (WORD_W),
        .CHAIN_LEN (CHAIN_LEN),
        .CNT_W     (CNT_W)
    ) dut (
        .config_clk     (clk),
        .config_reset   (rst_n),
        .start          (start),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .s_data         (s_data),
        .chain_shift_en (chain_shift_en),
        .chain_sdo      (chain_sdo),
        .chain_sdi      (chain_sdi),
        .busy           (busy),
        .done           (done),
        .error          (error)
    );

    // Chain model: first cell at bit 0, last cell at bit CHAIN_LEN-1.
    always @(posedge clk) begin
        if (chain_shift_en) chain_m <= {chain_m[CHAIN_LEN-2:0], chain_sdo} ^ flip_mask;
        else                chain_m <= chain_m ^ flip_mask;
    end
    assign chain_sdi = chain_m[CHAIN_LEN-1];

    task automatic check(input string tag, input int cyc,
                         input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s (cycle %0d): observed %0h, expected %0h", tag, cyc, obs, expv);
        end
    endtask

    task automatic check_cycle(input int cyc, input exp_t e);
        check("chain_shift_en", cyc, 64'(chain_shift_en), 64'(e.en));
        check("chain_sdo",      cyc, 64'(chain_sdo),      64'(e.sdo));
        check("s_ready",        cyc, 64'(s_ready),        64'(e.rdy));
        check("busy",           cyc, 64'(busy),           64'(e.busy));
        check("done",           cyc, 64'(done),           64'(e.done));
        check("error",          cyc, 64'(error),          64'(e.err));
    endtask

    task automatic check_all_zero(input string tag, input int cyc);
        check({tag, "_shift_en"}, cyc, 64'(chain_shift_en), 64'(0));
        check({tag, "_sdo"},      cyc, 64'(chain_sdo),      64'(0));
        check({tag, "_ready"},    cyc, 64'(s_ready),        64'(0));
        check({tag, "_busy"},     cyc, 64'(busy),           64'(0));
        check({tag, "_done"},     cyc, 64'(done),           64'(0));
        check({tag, "_error"},    cyc, 64'(error),          64'(0));
    endtask

    // One load: start at cycle 0, host words w0/w1, host stalls 'stall' cycles
    // at the second LOAD, optional start pulses at cycles 10 and 20, optional
    // model-chain bit flip after SHIFT, optional async reset at cycle reset_at.
    task automatic run_load(input logic [WORD_W-1:0] w0, input logic [WORD_W-1:0] w1,
                            input int stall, input bit pulse_starts,
                            input int flip_pos, input int reset_at);
        logic [WORD_W-1:0]    words [2];
        logic                 bits  [$];
        logic                 vbits [$];
        exp_t                 exp_q [$];
        exp_t                 e;
        logic [CHAIN_LEN-1:0] exp_chain;
        int                   sent;
        int                   k;
        int                   wi;
        int                   last_shift;
        int                   stall_left;
        int                   host_wi;
        bit                   exp_err;
        bit                   ready_obs;
        bit                   aborted;

        words[0] = w0;
        words[1] = w1;
        // Bit stream: words LSB-first, truncated to the chain length.
        for (int w = 0; w < 2; w++)
            for (int i = 0; i < WORD_W; i++)
                if (bits.size() < CHAIN_LEN) bits.push_back(words[w][i]);
        // Read-back stream: the last cell holds the first loaded bit.
        vbits = bits;
        if (flip_pos >= 0) vbits[CHAIN_LEN-1-flip_pos] = ~vbits[CHAIN_LEN-1-flip_pos];
        exp_err = 1'b0;
`ifdef CFG_LOADER_VERIFY_EN
        for (int j = 0; j < CHAIN_LEN; j++) exp_err ^= bits[j] ^ vbits[j];
`endif

        // Expected schedule.
        e = '0; e.err = prev_err; exp_q.push_back(e);
        sent = 0;
        wi   = 0;
        while (sent < CHAIN_LEN) begin
            k = (CHAIN_LEN - sent < WORD_W) ? CHAIN_LEN - sent : WORD_W;
            for (int s = 0; s <= ((wi == 1) ? stall : 0); s++) begin
                e = '0; e.rdy = 1'b1; e.busy = 1'b1; exp_q.push_back(e);
            end
            for (int j = 0; j < k; j++) begin
                e = '0; e.en = 1'b1; e.sdo = bits[sent+j]; e.busy = 1'b1; exp_q.push_back(e);
            end
            sent += k;
            wi++;
        end
        last_shift = exp_q.size() - 1;
`ifdef CFG_LOADER_VERIFY_EN
        for (int j = 0; j < CHAIN_LEN; j++) begin
            e = '0; e.en = 1'b1; e.sdo = vbits[j]; e.busy = 1'b1; exp_q.push_back(e);
        end
`endif
        e = '0; e.busy = 1'b1; e.done = 1'b1; e.err = exp_err; exp_q.push_back(e);
        e = '0; e.err = exp_err; exp_q.push_back(e);

        host_wi    = 0;
        stall_left = stall;
        aborted    = 1'b0;
        for (int c = 0; c < exp_q.size() && !aborted; c++) begin
            @(negedge clk);
            check_cycle(c, exp_q[c]);
            ready_obs = s_ready;
            flip_mask = '0;
            if (c == last_shift && flip_pos >= 0) flip_mask[flip_pos] = 1'b1;
            start = (c == 0) || (pulse_starts && (c == 10 || c == 20));
            if (ready_obs && host_wi == 1 && stall_left > 0) begin
                s_valid = 1'b0;
                stall_left--;
            end else begin
                s_valid = (host_wi < 2);
            end
            s_data = words[(host_wi < 2) ? host_wi : 1];
            if (ready_obs && s_valid) host_wi++;
            if (c == reset_at) begin
                #2 rst_n = 1'b0;
                #1 check_all_zero("async_reset", c);
                @(negedge clk);
                check_all_zero("held_reset", c + 1);
                rst_n     = 1'b1;
                start     = 1'b0;
                s_valid   = 1'b0;
                flip_mask = '0;
                prev_err  = 1'b0;
                aborted   = 1'b1;
            end
        end

        if (!aborted) begin
            start   = 1'b0;
            s_valid = 1'b0;
            for (int j = 0; j < CHAIN_LEN; j++) exp_chain[CHAIN_LEN-1-j] = vbits[j];
            check("chain_contents", exp_q.size(), 64'(chain_m), 64'(exp_chain));
            prev_err = exp_err;
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset_value", -1);
        rst_n = 1'b1;
        @(negedge clk);

        // Two-word load (done at 43, or 83 with verify), then host stall.
        run_load(32'hA5A5_A5A5, 32'h0000_00C3, 0, 1'b0, -1, -1);
        run_load(32'hA5A5_A5A5, 32'h0000_00C3, 5, 1'b0, -1, -1);
        // Starts while busy are ignored.
        run_load($urandom, $urandom, 0, 1'b1, -1, -1);
`ifdef CFG_LOADER_VERIFY_EN
        // Corrupted chain flags error; the next start clears it.
        run_load($urandom, $urandom, 0, 1'b0, 17, -1);
        run_load($urandom, $urandom, 2, 1'b0, -1, -1);
`endif
        // Reset mid-SHIFT, then a fresh load with unchanged timing.
        run_load($urandom, $urandom, 0, 1'b0, -1, 15);
        run_load(32'hA5A5_A5A5, 32'h0000_00C3, 0, 1'b0, -1, -1);

        for (int n = 0; n < 6; n++)
            run_load($urandom, $urandom, int'($urandom_range(0, 4)),
                     1'($urandom_range(0, 1)), -1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
